// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: staged release after power-on or a debounced button,
// with per-domain debug hold and a last-reset-cause indication.

module reset_sequencer_dbg_lane #(
  parameter int StepCycles = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic req_i,
  output logic ok_d_o
);
  localparam int SW = $clog2(StepCycles + 1);

  logic [SW-1:0] cnt_q, cnt_d;
  logic          ok_q,  ok_d;

  // A request holds the domain and restarts the countdown; release comes StepCycles edges after it drops.
  always_comb begin
    ok_d  = ok_q;
    cnt_d = cnt_q;
    if (!run_i || req_i) begin
      ok_d  = 1'b0;
      cnt_d = '0;
    end else if (!ok_q) begin
      if (cnt_q == SW'(StepCycles - 1)) begin
        ok_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ok_q  <= ok_d;
      cnt_q <= cnt_d;
    end
  end

  assign ok_d_o = ok_d;
endmodule

module reset_sequencer #(
  parameter int Channels       = 3,
  parameter int PorCycles      = 16,
  parameter int StepCycles     = 4,
  parameter int DebounceCycles = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_reset_req,
  input  logic [Channels-1:0] dbg_reset_req,
  output logic [Channels-1:0] rst_n_out,
  output logic                busy,
  output logic                por_done,
  output logic [1:0]          cause
);
  localparam int MaxCyc = (PorCycles > StepCycles) ? PorCycles : StepCycles;
  localparam int CW     = $clog2(MaxCyc + 1);
  localparam int DW     = $clog2(DebounceCycles + 1);

  localparam logic [1:0] ST_POR  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [1:0] rst_sync_q, sw_sync_q;
  logic       run, sw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      sw_sync_q  <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      sw_sync_q  <= {sw_sync_q[0], sw_reset_req};
    end
  end

  assign run  = rst_sync_q[1];
  assign sw_s = sw_sync_q[1];

  // Button debounce: one trigger per press, re-armed only by a low sample.
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          armed_q, armed_d, trig_q, trig_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    armed_d  = armed_q;
    trig_d   = 1'b0;
    if (!run) begin
      db_cnt_d = '0;
      armed_d  = 1'b0;
    end else if (!sw_s) begin
      db_cnt_d = '0;
      armed_d  = 1'b1;
    end else if (armed_q) begin
      if (db_cnt_q == DW'(DebounceCycles - 1)) begin
        trig_d   = 1'b1;
        armed_d  = 1'b0;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  logic [Channels-1:0] dbg_ok_d;

  for (genvar i = 0; i < Channels; i++) begin : g_lane
    reset_sequencer_dbg_lane #(.StepCycles(StepCycles)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_i  (run),
      .req_i  (dbg_reset_req[i]),
      .ok_d_o (dbg_ok_d[i])
    );
  end

  logic [1:0]          state_q, state_d, cause_q, cause_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [Channels-1:0] seq_q, seq_d, seq_adv, out_q, out_d;
  logic                por_done_q, por_done_d;

  assign seq_adv = (seq_q << 1) | Channels'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    cause_d    = cause_q;
    por_done_d = por_done_q;
    if (!run) begin
      state_d = ST_POR;
      cnt_d   = '0;
      seq_d   = '0;
    end else if (trig_q && state_q != ST_HOLD) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      seq_d   = '0;
      cause_d = 2'b01;
    end else begin
      case (state_q)
        ST_POR, ST_HOLD, ST_REL: begin
          if (cnt_q == ((state_q == ST_REL) ? CW'(StepCycles - 1) : CW'(PorCycles - 1))) begin
            cnt_d   = '0;
            seq_d   = seq_adv;
            state_d = ST_REL;
            if (seq_adv[Channels-1]) begin
              state_d    = ST_RUN;
              por_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered from next-state values so the pins change exactly at the deciding edge.
  assign out_d = seq_d & dbg_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_POR;
      cnt_q      <= '0;
      seq_q      <= '0;
      cause_q    <= 2'b00;
      por_done_q <= 1'b0;
      out_q      <= '0;
      db_cnt_q   <= '0;
      armed_q    <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      cause_q    <= cause_d;
      por_done_q <= por_done_d;
      out_q      <= out_d;
      db_cnt_q   <= db_cnt_d;
      armed_q    <= armed_d;
      trig_q     <= trig_d;
    end
  end

  assign rst_n_out = out_q;
  assign busy      = (state_q != ST_RUN);
  assign por_done  = por_done_q;
  assign cause     = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed table-driven bench for reset_sequencer (3 channels, 16/4/8 timing).

module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [2:0] dbg_reset_req = 3'b000;
  logic [2:0] rst_n_out;
  logic       busy, por_done;
  logic [1:0] cause;

  always #5 clk = ~clk;

  reset_sequencer #(.Channels(3), .PorCycles(16), .StepCycles(4), .DebounceCycles(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_reset_req  (sw_reset_req),
    .dbg_reset_req (dbg_reset_req),
    .rst_n_out     (rst_n_out),
    .busy          (busy),
    .por_done      (por_done),
    .cause         (cause)
  );

  typedef struct {
    int         at;
    logic       sw;
    logic [2:0] dbg;
    logic [2:0] out;
    logic       busy;
    logic       pd;
    logic [1:0] cause;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vec_t por_q[$];
  vec_t main_q[$];
  vec_t dbg_q[$];

  function automatic vec_t mk(int at, logic s, logic [2:0] d, logic [2:0] o,
                              logic b, logic p, logic [1:0] c);
    vec_t v;
    v.at = at; v.sw = s; v.dbg = d; v.out = o; v.busy = b; v.pd = p; v.cause = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk($sformatf("%s rst_n_out@%0d", tag, v.at), {29'd0, rst_n_out}, {29'd0, v.out});
    chk($sformatf("%s busy@%0d", tag, v.at), {31'd0, busy}, {31'd0, v.busy});
    chk($sformatf("%s por_done@%0d", tag, v.at), {31'd0, por_done}, {31'd0, v.pd});
    chk($sformatf("%s cause@%0d", tag, v.at), {30'd0, cause}, {30'd0, v.cause});
  endtask

  task automatic apply(input string tag, input vec_t v);
    sw_reset_req  = v.sw;
    dbg_reset_req = v.dbg;
    while (cyc < v.at) tick();
    chk_all(tag, v);
  endtask

  task automatic power_up();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up release timing (edges counted from rst_n rising)
    por_q.push_back(mk( 2, 0, 3'b000, 3'b000, 1, 0, 2'b00));
    por_q.push_back(mk(17, 0, 3'b000, 3'b000, 1, 0, 2'b00));
    por_q.push_back(mk(18, 0, 3'b000, 3'b001, 1, 0, 2'b00));
    por_q.push_back(mk(21, 0, 3'b000, 3'b001, 1, 0, 2'b00));
    por_q.push_back(mk(22, 0, 3'b000, 3'b011, 1, 0, 2'b00));
    por_q.push_back(mk(25, 0, 3'b000, 3'b011, 1, 0, 2'b00));
    por_q.push_back(mk(26, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    // Debug hold on channel 2 for 3 edges
    main_q.push_back(mk( 30, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 31, 0, 3'b100, 3'b011, 0, 1, 2'b00));
    main_q.push_back(mk( 33, 0, 3'b100, 3'b011, 0, 1, 2'b00));
    main_q.push_back(mk( 36, 0, 3'b000, 3'b011, 0, 1, 2'b00));
    main_q.push_back(mk( 37, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    // Button: 7 cycles is too short, 8 triggers
    main_q.push_back(mk( 40, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 47, 1, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 60, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 68, 1, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 70, 0, 3'b000, 3'b111, 0, 1, 2'b00));
    main_q.push_back(mk( 71, 0, 3'b000, 3'b000, 1, 1, 2'b01));
    main_q.push_back(mk( 86, 0, 3'b000, 3'b000, 1, 1, 2'b01));
    main_q.push_back(mk( 87, 0, 3'b000, 3'b001, 1, 1, 2'b01));
    main_q.push_back(mk( 90, 0, 3'b000, 3'b001, 1, 1, 2'b01));
    main_q.push_back(mk( 91, 0, 3'b000, 3'b011, 1, 1, 2'b01));
    main_q.push_back(mk( 94, 0, 3'b000, 3'b011, 1, 1, 2'b01));
    main_q.push_back(mk( 95, 0, 3'b000, 3'b111, 0, 1, 2'b01));
    // Long press gives one trigger; re-press after release triggers again
    main_q.push_back(mk(100, 0, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(110, 1, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(111, 1, 3'b000, 3'b000, 1, 1, 2'b01));
    main_q.push_back(mk(134, 1, 3'b000, 3'b011, 1, 1, 2'b01));
    main_q.push_back(mk(135, 1, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(200, 1, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(210, 0, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(218, 1, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(220, 0, 3'b000, 3'b111, 0, 1, 2'b01));
    main_q.push_back(mk(221, 0, 3'b000, 3'b000, 1, 1, 2'b01));
    // Channel 0 debug request held through power-up, dropped after edge 40
    dbg_q.push_back(mk(18, 0, 3'b001, 3'b000, 1, 0, 2'b00));
    dbg_q.push_back(mk(22, 0, 3'b001, 3'b010, 1, 0, 2'b00));
    dbg_q.push_back(mk(25, 0, 3'b001, 3'b010, 1, 0, 2'b00));
    dbg_q.push_back(mk(26, 0, 3'b001, 3'b110, 0, 1, 2'b00));
    dbg_q.push_back(mk(40, 0, 3'b001, 3'b110, 0, 1, 2'b00));
    dbg_q.push_back(mk(43, 0, 3'b000, 3'b110, 0, 1, 2'b00));
    dbg_q.push_back(mk(44, 0, 3'b000, 3'b111, 0, 1, 2'b00));

    repeat (5) @(posedge clk);
    #1;
    chk_all("reset", mk(0, 0, 3'b000, 3'b000, 1, 0, 2'b00));
    rst_n = 1'b1;
    cyc = 0;
    foreach (por_q[i])  apply("por", por_q[i]);
    foreach (main_q[i]) apply("run", main_q[i]);

    // Power-up with a prior cause of button: reset clears it
    sw_reset_req  = 1'b0;
    dbg_reset_req = 3'b001;
    power_up();
    foreach (dbg_q[i]) apply("dbg", dbg_q[i]);

    // Reset while in RUN clears sticky por_done
    rst_n = 1'b0;
    #2;
    chk_all("rst_run", mk(44, 0, 3'b000, 3'b000, 1, 0, 2'b00));

    // Reset mid-release: outputs drop asynchronously, sequence restarts
    dbg_reset_req = 3'b000;
    power_up();
    apply("mid", mk(20, 0, 3'b000, 3'b001, 1, 0, 2'b00));
    rst_n = 1'b0;
    #2;
    chk_all("rst_mid", mk(20, 0, 3'b000, 3'b000, 1, 0, 2'b00));
    power_up();
    foreach (por_q[i]) apply("repor", por_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
